// File: rtl/vload_word_sequencer.sv
// Splits a unit-stride vector load into single-outstanding 32-bit word reads and tags each
// returned word with SEW, word slot, destination register and lane enables. Optional: VLOAD_BUS_ERR_EN.
module vload_word_sequencer #(
   parameter int ADDR_W = 32,
   parameter int VL_W   = 8,
   parameter int VREG_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [VL_W-1:0]   vl_i,
   input  logic [1:0]        sew_i,
   input  logic [VREG_W-1:0] vd_i,
   output logic              busy_o,
   output logic              done_o,
`ifdef VLOAD_BUS_ERR_EN
   input  logic              data_err_i,
   output logic              err_o,
`endif
   output logic              data_req_o,
   output logic [ADDR_W-1:0] data_addr_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i,
   output logic              map_valid_o,
   input  logic              map_ready_i,
   output logic [31:0]       map_data_o,
   output logic [1:0]        map_sew_o,
   output logic [1:0]        map_reg_select_o,
   output logic [VREG_W-1:0] map_vd_o,
   output logic [3:0]        map_elem_en_o,
   output logic              map_last_o
);

   localparam int EI_W = VL_W + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_FINISH
   } state_t;

   state_t            r_state;
   logic [VL_W-1:0]   r_vl;
   logic [VL_W-1:0]   r_words;
   logic [VL_W-1:0]   r_k;
   logic [1:0]        r_sew;
   logic [VREG_W-1:0] r_vd;

   logic [VL_W-1:0]   w_words;
   logic [ADDR_W-1:0] w_base_aligned;
   logic              w_last;
   logic [1:0]        w_reg_select;
   logic [VL_W-1:0]   w_vd_off;
   logic [VREG_W-1:0] w_vd;
   logic [3:0]        w_elem_en;

   // Ceiling division written as shift plus remainder flag so no extra carry bit is needed.
   always_comb begin
      w_words = '0;
      case (sew_i)
         2'd0:    w_words = (vl_i >> 2) + VL_W'(vl_i[1:0] != 2'b00);
         2'd1:    w_words = (vl_i >> 1) + VL_W'(vl_i[0]);
         2'd2:    w_words = vl_i;
         default: w_words = '0;
      endcase
   end

   assign w_base_aligned = base_addr_i & ~ADDR_W'(3);
   assign w_last         = (r_k == (r_words - VL_W'(1)));

   always_comb begin
      w_reg_select = 2'd0;
      w_vd_off     = r_k;
      case (r_sew)
         2'd1: begin
            w_reg_select = {1'b0, r_k[0]};
            w_vd_off     = r_k >> 1;
         end
         2'd2: begin
            w_reg_select = r_k[1:0];
            w_vd_off     = r_k >> 2;
         end
         default: begin
            w_reg_select = 2'd0;
            w_vd_off     = r_k;
         end
      endcase
   end

   assign w_vd = r_vd + VREG_W'(w_vd_off);

   // Each lane is enabled when it carries an element of this word and that element is below vl.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [EI_W-1:0] w_idx;
         logic            w_lane_ok;
         always_comb begin
            w_idx     = '0;
            w_lane_ok = 1'b0;
            case (r_sew)
               2'd0: begin
                  w_idx     = {r_k, 2'b00} + EI_W'(gi);
                  w_lane_ok = 1'b1;
               end
               2'd1: begin
                  w_idx     = {1'b0, r_k, 1'b0} + EI_W'(gi % 2);
                  w_lane_ok = ((gi / 2) == int'(r_k[0]));
               end
               2'd2: begin
                  w_idx     = {2'b00, r_k};
                  w_lane_ok = (gi == int'(r_k[1:0]));
               end
               default: begin
                  w_idx     = '0;
                  w_lane_ok = 1'b0;
               end
            endcase
         end
         assign w_elem_en[gi] = w_lane_ok && (w_idx < {2'b00, r_vl});
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state          <= S_IDLE;
         r_vl             <= '0;
         r_words          <= '0;
         r_k              <= '0;
         r_sew            <= '0;
         r_vd             <= '0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
`ifdef VLOAD_BUS_ERR_EN
         err_o            <= 1'b0;
`endif
         data_req_o       <= 1'b0;
         data_addr_o      <= '0;
         map_valid_o      <= 1'b0;
         map_data_o       <= '0;
         map_sew_o        <= '0;
         map_reg_select_o <= '0;
         map_vd_o         <= '0;
         map_elem_en_o    <= '0;
         map_last_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
`ifdef VLOAD_BUS_ERR_EN
         err_o  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_vl        <= vl_i;
                  r_words     <= w_words;
                  r_k         <= '0;
                  r_sew       <= sew_i;
                  r_vd        <= vd_i;
                  busy_o      <= 1'b1;
                  data_addr_o <= w_base_aligned;
                  if (w_words == '0) begin
                     r_state <= S_FINISH;
                     done_o  <= 1'b1;
                  end else begin
                     r_state    <= S_REQ;
                     data_req_o <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (data_rvalid_i) begin
`ifdef VLOAD_BUS_ERR_EN
                  if (data_err_i) begin
                     r_state <= S_FINISH;
                     done_o  <= 1'b1;
                     err_o   <= 1'b1;
                  end else begin
                     map_valid_o      <= 1'b1;
                     map_data_o       <= data_rdata_i;
                     map_sew_o        <= r_sew;
                     map_reg_select_o <= w_reg_select;
                     map_vd_o         <= w_vd;
                     map_elem_en_o    <= w_elem_en;
                     map_last_o       <= w_last;
                     r_state          <= S_OUT;
                  end
`else
                  map_valid_o      <= 1'b1;
                  map_data_o       <= data_rdata_i;
                  map_sew_o        <= r_sew;
                  map_reg_select_o <= w_reg_select;
                  map_vd_o         <= w_vd;
                  map_elem_en_o    <= w_elem_en;
                  map_last_o       <= w_last;
                  r_state          <= S_OUT;
`endif
               end
            end
            S_OUT: begin
               if (map_ready_i) begin
                  map_valid_o <= 1'b0;
                  map_last_o  <= 1'b0;
                  if (w_last) begin
                     r_state <= S_FINISH;
                     done_o  <= 1'b1;
                  end else begin
                     r_k         <= r_k + VL_W'(1);
                     data_addr_o <= data_addr_o + ADDR_W'(4);
                     data_req_o  <= 1'b1;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_FINISH: begin
               busy_o  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               busy_o     <= 1'b0;
               data_req_o <= 1'b0;
               map_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vload_word_sequencer.sv
// Randomized scoreboard bench for vload_word_sequencer: a memory responder, a sink/monitor and
// a command driver, with expected beats derived from element/word arithmetic.
module tb_vload_word_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic [7:0]  vl_i;
   logic [1:0]  sew_i;
   logic [4:0]  vd_i;
   logic        busy_o, done_o;
   logic        data_req_o;
   logic [31:0] data_addr_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        map_valid_o, map_ready_i;
   logic [31:0] map_data_o;
   logic [1:0]  map_sew_o, map_reg_select_o;
   logic [4:0]  map_vd_o;
   logic [3:0]  map_elem_en_o;
   logic        map_last_o;
`ifdef VLOAD_BUS_ERR_EN
   logic        data_err_i;
   logic        err_o;
`endif

   always #5 clk_i = ~clk_i;

   vload_word_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .vl_i(vl_i), .sew_i(sew_i), .vd_i(vd_i), .busy_o(busy_o), .done_o(done_o),
`ifdef VLOAD_BUS_ERR_EN
      .data_err_i(data_err_i), .err_o(err_o),
`endif
      .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_gnt_i(data_gnt_i),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .map_valid_o(map_valid_o), .map_ready_i(map_ready_i), .map_data_o(map_data_o),
      .map_sew_o(map_sew_o), .map_reg_select_o(map_reg_select_o), .map_vd_o(map_vd_o),
      .map_elem_en_o(map_elem_en_o), .map_last_o(map_last_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  sew;
      logic [1:0]  rs;
      logic [4:0]  vd;
      logic [3:0]  en;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] addr_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          fast     = 1'b1;
   bit          err_mode = 1'b0;
   int          rsp_min  = 0;
   logic [31:0] err_addr = 32'h0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0] + 16'h1234};
   endfunction

   task automatic tb_check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tb_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
   endtask

   // Reference: element i of the command lives in word i/epw; words fill a register P at a time.
   function automatic int push_cmd(input logic [31:0] base, input int vl, input int sew,
                                   input logic [4:0] vd);
      beat_t b;
      int    epw, pp, w;
      if (sew == 3) return 0;
      epw = 4 >> sew;
      pp  = 1 << sew;
      w   = (vl + epw - 1) / epw;
      for (int k = 0; k < w; k++) begin
         b.addr = (base & 32'hFFFF_FFFC) + 32'(4 * k);
         b.sew  = 2'(sew);
         b.rs   = 2'(k % pp);
         b.vd   = vd + 5'(k / pp);
         b.en   = '0;
         for (int e = 0; e < epw; e++)
            if (k * epw + e < vl) b.en[(k % pp) * epw + e] = 1'b1;
         b.last = (k == w - 1);
         exp_q.push_back(b);
         addr_q.push_back(b.addr);
      end
      return w;
   endfunction

   // Memory responder: random grant delay, random response delay, stray responses while in OUT.
   initial begin
      int          gdly = -1;
      bit          have_rsp = 1'b0;
      int          rdly = 0;
      logic [31:0] raddr = '0;
      logic [31:0] first_addr = '0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
`ifdef VLOAD_BUS_ERR_EN
      data_err_i = 1'b0;
`endif
      forever begin
         @(negedge clk_i);
         data_gnt_i    = 1'b0;
         data_rvalid_i = 1'b0;
         data_rdata_i  = $urandom;
`ifdef VLOAD_BUS_ERR_EN
         data_err_i    = 1'b0;
`endif
         if (have_rsp) begin
            if (rdly == 0) begin
               data_rvalid_i = 1'b1;
               data_rdata_i  = memf(raddr);
`ifdef VLOAD_BUS_ERR_EN
               data_err_i    = err_mode && (raddr == err_addr);
`endif
               have_rsp = 1'b0;
            end else begin
               rdly--;
            end
         end else if (data_req_o && !rst_i) begin
            if (gdly < 0) begin
               gdly = fast ? 0 : $urandom_range(0, 3);
               first_addr = data_addr_o;
            end else begin
               tb_check("addr_stable", data_addr_o, first_addr);
            end
            if (gdly == 0) begin
               data_gnt_i = 1'b1;
               raddr      = data_addr_o;
               have_rsp   = 1'b1;
               rdly       = fast ? 0 : $urandom_range(rsp_min, rsp_min + 2);
               gdly       = -1;
               if (addr_q.size() == 0) tb_fail("unexpected_req");
               else tb_check("req_addr", data_addr_o, addr_q.pop_front());
            end else begin
               gdly--;
            end
         end else if (map_valid_o && $urandom_range(0, 3) == 0) begin
            data_rvalid_i = 1'b1;
         end
         if (rst_i) gdly = -1;
      end
   end

   // Sink and monitor: chooses map_ready_i, checks each accepted beat and done_o timing.
   initial begin
      bit          held_v = 1'b0;
      logic [63:0] held = '0;
      logic [63:0] cur;
      bit          prev_ev = 1'b0;
      bit          ev;
      bit          rdy;
      beat_t       e;
      map_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            held_v = 1'b0; prev_ev = 1'b0; map_ready_i = 1'b0;
            continue;
         end
         if (!err_mode) tb_check("done_timing", done_o, prev_ev);
`ifdef VLOAD_BUS_ERR_EN
         if (!err_mode) tb_check("err_quiet", err_o, 0);
`endif
         ev = start_i && !busy_o && (sew_i == 2'd3 || vl_i == 8'd0);
         cur = {18'h0, map_data_o, map_sew_o, map_reg_select_o, map_vd_o, map_elem_en_o, map_last_o};
         if (map_valid_o) begin
            if (held_v) tb_check("map_stable", cur, held);
            rdy = fast ? 1'b1 : ($urandom_range(0, 9) < 6);
            map_ready_i = rdy;
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  tb_fail("unexpected_beat");
               end else begin
                  e = exp_q.pop_front();
                  tb_check("beat_data", map_data_o, memf(e.addr));
                  tb_check("beat_sew", map_sew_o, e.sew);
                  tb_check("beat_rs", map_reg_select_o, e.rs);
                  tb_check("beat_vd", map_vd_o, e.vd);
                  tb_check("beat_en", map_elem_en_o, e.en);
                  tb_check("beat_last", map_last_o, e.last);
                  if (e.last) ev = 1'b1;
               end
               held_v = 1'b0;
            end else begin
               held_v = 1'b1;
               held   = cur;
            end
         end else begin
            map_ready_i = 1'($urandom_range(0, 1));
            held_v = 1'b0;
         end
         prev_ev = ev;
      end
   end

   task automatic garbage();
      base_addr_i = $urandom;
      vl_i        = 8'($urandom);
      sew_i       = 2'($urandom);
      vd_i        = 5'($urandom);
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (busy_o) begin
         @(posedge clk_i); #1;
         cyc++;
         if (cyc > 3000) begin
            tb_check("idle_timeout", busy_o, 0);
            break;
         end
      end
   endtask

   task automatic issue(input logic [31:0] base, input int vl, input int sew,
                        input logic [4:0] vd, output int w);
      wait_idle();
      w = push_cmd(base, vl, sew, vd);
      $display("[TB] cmd base=%08h vl=%0d sew=%0d vd=%0d words=%0d", base, vl, sew, vd, w);
      base_addr_i = base; vl_i = 8'(vl); sew_i = 2'(sew); vd_i = vd; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      garbage();
   endtask

   task automatic run_cmd(input logic [31:0] base, input int vl, input int sew,
                          input logic [4:0] vd, input bit lat);
      int w;
      int cyc = 0;
      issue(base, vl, sew, vd, w);
      if (lat) begin
         tb_check("req_latency", data_req_o, 64'(w != 0));
         if (w == 0) begin
            tb_check("done_latency", done_o, 1);
         end else begin
            repeat (2) begin @(posedge clk_i); #1; end
            tb_check("valid_latency", map_valid_o, 1);
         end
      end
      while (busy_o) begin
         if (!lat && $urandom_range(0, 7) == 0) begin
            garbage();
            start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk_i); #1;
         cyc++;
         if (cyc > 3000) begin
            tb_check("cmd_timeout", busy_o, 0);
            break;
         end
      end
      start_i = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected finish by %0t", $time);
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cyc;
      rst_i = 1'b1; start_i = 1'b0;
      base_addr_i = '0; vl_i = '0; sew_i = '0; vd_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      tb_check("reset_ctrl", {busy_o, done_o, data_req_o, map_valid_o, map_last_o,
                              map_sew_o, map_reg_select_o, map_vd_o, map_elem_en_o}, 0);
      tb_check("reset_data", {data_addr_o, map_data_o}, 0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      fast = 1'b1;
      run_cmd(32'h0000_0100, 8, 0, 5'd2, 1'b1);
      run_cmd(32'h0000_0203, 3, 1, 5'd7, 1'b1);
      run_cmd(32'h0000_0040, 5, 2, 5'd4, 1'b1);
      run_cmd(32'h0000_0080, 0, 0, 5'd1, 1'b1);
      run_cmd(32'h0000_0090, 7, 3, 5'd1, 1'b1);
      run_cmd(32'hFFFF_FFF8, 12, 2, 5'd30, 1'b0);

      fast = 1'b0;
      run_cmd(32'h0000_1000, 255, 0, 5'd9, 1'b0);
      for (int i = 0; i < 40; i++) begin
         int s, v;
         s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         v = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
         run_cmd($urandom, v, s, 5'($urandom), 1'b0);
      end

      // Reset while waiting on a response; the late response must be ignored.
      rsp_min = 3;
      issue(32'h0000_0500, 8, 2, 5'd3, w);
      cyc = 0;
      while (!(busy_o && !data_req_o && !map_valid_o && !done_o) && cyc < 200) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      tb_check("reached_wait", {busy_o, data_req_o, map_valid_o}, 3'b100);
      rst_i = 1'b1;
      exp_q.delete();
      addr_q.delete();
      @(posedge clk_i); #1;
      tb_check("rst_ctrl", {busy_o, done_o, data_req_o, map_valid_o, map_last_o,
                            map_sew_o, map_reg_select_o, map_vd_o, map_elem_en_o}, 0);
      tb_check("rst_data", {data_addr_o, map_data_o}, 0);
      rst_i = 1'b0;
      repeat (8) begin @(posedge clk_i); #1; end
      tb_check("quiet_after_rst", {busy_o, data_req_o, map_valid_o}, 0);
      rsp_min = 0;
      run_cmd(32'h0000_0600, 6, 1, 5'd12, 1'b0);

`ifdef VLOAD_BUS_ERR_EN
      wait_idle();
      err_mode = 1'b1;
      err_addr = 32'h0000_0304;
      issue(32'h0000_0300, 4, 2, 5'd1, w);
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      while (addr_q.size() > 2) void'(addr_q.pop_back());
      exp_q[0].last = 1'b0;
      cyc = 0;
      while (!done_o && cyc < 200) begin
         @(posedge clk_i); #1;
         cyc++;
      end
      tb_check("err_done", {done_o, err_o}, 2'b11);
      @(posedge clk_i); #1;
      tb_check("err_pulse", {done_o, err_o, busy_o}, 0);
      err_mode = 1'b0;
`endif

      wait_idle();
      repeat (10) begin @(posedge clk_i); #1; end
      tb_check("beats_drained", exp_q.size(), 0);
      tb_check("reqs_drained", addr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
